// File: rtl/arb_requester.sv
// Requester-side client of a round-robin arbiter: queues local commands, requests
// ownership, streams up to MAX_BURST words per grant. Optional macro: ARB_REQ_TIMEOUT_EN.
module arb_requester #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 4,
   parameter int MAX_BURST = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                     hostCLK,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [DATA_W-1:0]        cmd_data,
   output logic                     request,
   input  logic                     grant,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [DATA_W-1:0]        res_data,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_params
      $error("arb_requester: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, REQ, OWN, RELEASE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic              push, pop, empty, full;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   // Held low during reset so nothing is accepted while the FIFO is being cleared.
   assign cmd_ready = !reset && !full;
   assign push      = cmd_valid && cmd_ready;
   assign res_valid = (state_q == OWN) && grant && !empty;
   assign pop       = res_valid && res_ready;
   assign res_data  = mem_q[rd_ptr_q];
   assign request   = (state_q == REQ) || (state_q == OWN);
   assign busy      = (state_q != IDLE);
   assign count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      case (state_q)
         IDLE: begin
            if (!empty) state_d = REQ;
         end
         REQ: begin
            if (grant) begin
               state_d = OWN;
               burst_d = '0;
            end
         end
         OWN: begin
            // A grant lost mid-ownership is a protocol violation: give up the slot.
            if (!grant) begin
               state_d = RELEASE;
            end else if (pop) begin
               burst_d = burst_q + BW'(1);
               if (burst_d == BURST_MAX || count_d == '0) state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hostCLK or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         burst_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         burst_q  <= burst_d;
      end
   end

   always_ff @(posedge hostCLK) begin
      if (push) mem_q[wr_ptr_q] <= cmd_data;
   end

`ifdef ARB_REQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

   logic [TW-1:0] wait_q, wait_d;
   logic          timeout_q, timeout_d;

   // Wait counter saturates at TIMEOUT; the flag is sticky until reset.
   always_comb begin
      wait_d    = '0;
      timeout_d = timeout_q;
      if (state_q == REQ) begin
         wait_d = (wait_q == TO_MAX) ? wait_q : wait_q + TW'(1);
         if (wait_d == TO_MAX) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge hostCLK or posedge reset) begin
      if (reset) begin
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: cycle table for the main flows plus hand
// sequences for grant-wait timeout and asynchronous reset during ownership.
module tb_arb_requester;

   logic        hostCLK = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_data;
   logic        request;
   logic        grant;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        busy;
   logic [2:0]  count;
   logic        timeout;

   logic g_follow = 1'b0;
   logic g_force  = 1'b0;

`ifdef ARB_REQ_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   always #5 hostCLK = ~hostCLK;

   assign grant = g_follow ? request : g_force;

   arb_requester #(
      .DATA_W(16), .DEPTH(4), .MAX_BURST(4), .TIMEOUT(8)
   ) dut (
      .hostCLK(hostCLK), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .request(request), .grant(grant),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .count(count), .timeout(timeout)
   );

   typedef struct {
      logic        cv;
      logic [15:0] d;
      logic        gf;
      logic        gv;
      logic        rr;
      logic        e_rdy;
      logic        e_req;
      logic        e_rv;
      logic [15:0] e_rd;
      logic        e_bsy;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic add(input logic cv, input logic [15:0] d, input logic gf, input logic gv,
                      input logic rr, input logic rdy, input logic rq, input logic rv,
                      input logic [15:0] rd, input logic bsy, input logic [2:0] cnt);
      vec_t v;
      v.cv = cv; v.d = d; v.gf = gf; v.gv = gv; v.rr = rr;
      v.e_rdy = rdy; v.e_req = rq; v.e_rv = rv; v.e_rd = rd; v.e_bsy = bsy; v.e_cnt = cnt;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //  cv  data      gf gv rr   rdy req rv  res_data  bsy cnt
      // single word, grant tied to request
      add(1, 16'hA5A5, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 0);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  0,  16'h0000, 1, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  1,  16'hA5A5, 1, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 1, 0);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 0);
      // six words, burst of four then re-request for the last two
      add(1, 16'h1000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 0);
      add(1, 16'h1001, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 1);
      add(1, 16'h1002, 1, 0, 1,   1,  1,  0,  16'h0000, 1, 2);
      add(1, 16'h1003, 1, 0, 1,   1,  1,  1,  16'h1000, 1, 3);
      add(1, 16'h1004, 1, 0, 1,   1,  1,  1,  16'h1001, 1, 3);
      add(1, 16'h1005, 1, 0, 1,   1,  1,  1,  16'h1002, 1, 3);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  1,  16'h1003, 1, 3);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 1, 2);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 2);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  0,  16'h0000, 1, 2);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  1,  16'h1004, 1, 2);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  1,  16'h1005, 1, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 1, 0);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 0);
      // fill with grant low, fifth push refused, then push+pop while owning
      add(1, 16'h2000, 0, 0, 1,   1,  0,  0,  16'h0000, 0, 0);
      add(1, 16'h2001, 0, 0, 1,   1,  0,  0,  16'h0000, 0, 1);
      add(1, 16'h2002, 0, 0, 1,   1,  1,  0,  16'h0000, 1, 2);
      add(1, 16'h2003, 0, 0, 1,   1,  1,  0,  16'h0000, 1, 3);
      add(1, 16'h2004, 0, 0, 1,   0,  1,  0,  16'h0000, 1, 4);
      add(1, 16'h2004, 1, 0, 1,   0,  1,  0,  16'h0000, 1, 4);
      add(1, 16'h2004, 1, 0, 1,   0,  1,  1,  16'h2000, 1, 4);
      add(1, 16'h2004, 1, 0, 1,   1,  1,  1,  16'h2001, 1, 3);
      add(1, 16'h2005, 1, 0, 1,   1,  1,  1,  16'h2002, 1, 3);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  1,  16'h2003, 1, 3);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 1, 2);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 2);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  0,  16'h0000, 1, 2);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  1,  16'h2004, 1, 2);
      // back-pressure from the resource for three cycles
      add(0, 16'h0000, 1, 0, 0,   1,  1,  1,  16'h2005, 1, 1);
      add(0, 16'h0000, 1, 0, 0,   1,  1,  1,  16'h2005, 1, 1);
      add(0, 16'h0000, 1, 0, 0,   1,  1,  1,  16'h2005, 1, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  1,  16'h2005, 1, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 1, 0);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 0);
      // grant withdrawn while owning: no pop, release, word re-requested
      add(1, 16'h3000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 0);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  0,  16'h0000, 1, 1);
      add(0, 16'h0000, 0, 0, 1,   1,  1,  0,  16'h0000, 1, 1);
      add(0, 16'h0000, 0, 0, 1,   1,  0,  0,  16'h0000, 1, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  0,  16'h0000, 1, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  1,  1,  16'h3000, 1, 1);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 1, 0);
      add(0, 16'h0000, 1, 0, 1,   1,  0,  0,  16'h0000, 0, 0);

      // reset state
      reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; res_ready = 1'b0;
      repeat (2) @(negedge hostCLK);
      #2;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_request",   32'(request),   32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_timeout",   32'(timeout),   32'd0);
      @(posedge hostCLK);
      #1 reset = 1'b0;

      foreach (vecs[i]) begin
         @(negedge hostCLK);
         cmd_valid = vecs[i].cv;
         cmd_data  = vecs[i].d;
         g_follow  = vecs[i].gf;
         g_force   = vecs[i].gv;
         res_ready = vecs[i].rr;
         #2;
         chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("v%0d_request", i),   32'(request),   32'(vecs[i].e_req));
         chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'(vecs[i].e_rv));
         chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].e_bsy));
         chk($sformatf("v%0d_count", i),     32'(count),     32'(vecs[i].e_cnt));
         chk($sformatf("v%0d_timeout", i),   32'(timeout),   32'd0);
         if (vecs[i].e_rv)
            chk($sformatf("v%0d_res_data", i), 32'(res_data), 32'(vecs[i].e_rd));
      end

      // grant-wait timeout: 8 cycles in REQ with grant low
      @(negedge hostCLK);
      g_follow = 1'b0; g_force = 1'b0; res_ready = 1'b1;
      cmd_valid = 1'b1; cmd_data = 16'h4000;
      @(negedge hostCLK);
      cmd_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge hostCLK);
         #2;
         chk($sformatf("to_wait%0d_request", k), 32'(request), 32'd1);
         chk($sformatf("to_wait%0d_timeout", k), 32'(timeout), 32'd0);
      end
      @(negedge hostCLK);
      #2;
      chk("to_set_timeout", 32'(timeout), 32'(TO_EN));
      chk("to_set_request", 32'(request), 32'd1);
      g_follow = 1'b1;
      @(negedge hostCLK);
      #2;
      chk("to_own_res_valid", 32'(res_valid), 32'd1);
      chk("to_own_res_data",  32'(res_data),  32'h4000);
      repeat (2) @(negedge hostCLK);
      #2;
      chk("to_after_busy",    32'(busy),    32'd0);
      chk("to_after_timeout", 32'(timeout), 32'(TO_EN));

      // asynchronous reset while owning with three words queued
      res_ready = 1'b0;
      @(negedge hostCLK); cmd_valid = 1'b1; cmd_data = 16'h5000;
      @(negedge hostCLK); cmd_data = 16'h5001;
      @(negedge hostCLK); cmd_data = 16'h5002;
      @(negedge hostCLK); cmd_valid = 1'b0;
      #2;
      chk("ar_pre_res_valid", 32'(res_valid), 32'd1);
      chk("ar_pre_count",     32'(count),     32'd3);
      chk("ar_pre_res_data",  32'(res_data),  32'h5000);
      reset = 1'b1;
      #1;
      chk("ar_request",   32'(request),   32'd0);
      chk("ar_res_valid", 32'(res_valid), 32'd0);
      chk("ar_count",     32'(count),     32'd0);
      chk("ar_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("ar_busy",      32'(busy),      32'd0);
      chk("ar_timeout",   32'(timeout),   32'd0);
      @(negedge hostCLK);
      reset = 1'b0; res_ready = 1'b1;
      #2;
      chk("ar_rel_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("ar_rel_count",     32'(count),     32'd0);
      @(negedge hostCLK);
      #2;
      chk("ar_idle_busy",      32'(busy),      32'd0);
      chk("ar_idle_res_valid", 32'(res_valid), 32'd0);
      chk("ar_idle_count",     32'(count),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
